// File: rtl/uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_frame                                                |
// | Description : UART frame serialiser paced by an external baud tick.        |
// |               Sends start, DATA_BITS LSB-first, optional parity, and       |
// |               STOP_BITS. Parity is built only when UART_TX_PARITY_EN is     |
// |               defined.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_ARM    = 3'd1;
    localparam logic [2:0] c_S_START  = 3'd2;
    localparam logic [2:0] c_S_DATA   = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd5;
`endif

    generate
        if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
            (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_busy;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid) begin
                        r_shift <= tx_data;
                        r_busy  <= 1'b1;
                        r_state <= c_S_ARM;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
`endif
                    end
                end
                // Waiting here puts the start edge on a tick so it lasts a full period.
                c_S_ARM: begin
                    if (baud_tick) begin
                        r_tx    <= 1'b0;
                        r_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (baud_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= c_S_DATA;
                    end
                end
                c_S_DATA: begin
                    if (baud_tick) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= c_S_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= c_S_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_S_PARITY: begin
                    if (baud_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= c_S_STOP;
                    end
                end
`endif
                c_S_STOP: begin
                    if (baud_tick) begin
                        if (r_stop_cnt == c_LAST_STOP) begin
                            r_busy  <= 1'b0;
                            r_state <= c_S_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == c_S_IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for uart_tx_frame: baud tick every 10 clk, frames sampled mid-bit.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic baud_tick = 1'b0;

    logic [7:0] data_a = '0;
    logic       valid_a = 1'b0;
    logic       rdy_a, tx_a, busy_a;
    logic [6:0] data_b = '0;
    logic       valid_b = 1'b0;
    logic       rdy_b, tx_b, busy_b;

    int passed = 0;
    int total = 0;
    int div = 0;
    logic trace [0:639];
    logic btrace [0:639];

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [15:0] E_A5 = 16'h054A;
    localparam logic [15:0] E_3C = 16'h0478;
    localparam logic [15:0] E_7F = 16'h07FE;
`else
    localparam int P = 0;
    localparam logic [15:0] E_A5 = 16'h034A;
    localparam logic [15:0] E_3C = 16'h0278;
    localparam logic [15:0] E_7F = 16'h03FE;
`endif
    localparam int NB_A = 1 + 8 + P + 1;
    localparam int NB_B = 1 + 7 + P + 2;

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_a),
        .tx_valid(valid_a), .tx_ready(rdy_a), .tx(tx_a), .busy(busy_a));

    uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_b),
        .tx_valid(valid_b), .tx_ready(rdy_b), .tx(tx_b), .busy(busy_b));

`ifdef UART_TX_PARITY_EN
    logic [7:0] data_c = '0;
    logic       valid_c = 1'b0;
    logic       rdy_c, tx_c, busy_c;
    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_c),
        .tx_valid(valid_c), .tx_ready(rdy_c), .tx(tx_c), .busy(busy_c));
`endif

    always #5 clk = ~clk;

    // Tick is set up on the falling edge so it is stable for the next rising edge.
    always @(negedge clk) begin
        div = (div == 9) ? 0 : div + 1;
        baud_tick = (div == 9);
    end

    function automatic logic cur_tx(input int sel);
        case (sel)
            0: return tx_a;
            1: return tx_b;
`ifdef UART_TX_PARITY_EN
            2: return tx_c;
`endif
            default: return 1'bx;
        endcase
    endfunction

    function automatic logic cur_busy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
`ifdef UART_TX_PARITY_EN
            2: return busy_c;
`endif
            default: return 1'bx;
        endcase
    endfunction

    function automatic logic cur_rdy(input int sel);
        case (sel)
            0: return rdy_a;
            1: return rdy_b;
`ifdef UART_TX_PARITY_EN
            2: return rdy_c;
`endif
            default: return 1'bx;
        endcase
    endfunction

    function automatic logic [15:0] exp_frame(input logic [7:0] d, input int nd, input int ns);
        logic [15:0] f;
        logic p;
        f = '0;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f[1+i] = d[i];
            p = p ^ d[i];
        end
        if (P == 1) f[1+nd] = p;
        for (int s = 0; s < ns; s++) f[1+nd+P+s] = 1'b1;
        return f;
    endfunction

    task automatic drive(input int sel, input logic [7:0] d, input logic v);
        case (sel)
            0: begin data_a = d; valid_a = v; end
            1: begin data_b = d[6:0]; valid_b = v; end
`ifdef UART_TX_PARITY_EN
            2: begin data_c = d; valid_c = v; end
`endif
            default: ;
        endcase
    endtask

    // Leaves time at negedge+1 with baud_tick about to fire on the next rising edge.
    task automatic wait_tick_setup();
        int w;
        w = 0;
        do begin
            @(negedge clk); #1;
            w++;
        end while (!baud_tick && w < 30);
    endtask

    // Sends one word; index 0 of the trace is the accepting edge.
    task automatic run_frame(input int sel, input logic [7:0] d, input bit same_tick, input int nb,
                             output int lat, output int busy_cyc, output logic [15:0] bits,
                             output int start_len);
        for (int c = 0; c < 640; c++) trace[c] = 1'bx;
        wait_tick_setup();
        if (!same_tick) begin @(negedge clk); #1; end
        total++;
        if (cur_rdy(sel) !== 1'b1) $display("FAIL ready_before_send sel=%0d got=%b want=1", sel, cur_rdy(sel));
        else passed++;
        drive(sel, d, 1'b1);
        @(posedge clk); #1;
        drive(sel, 8'h00, 1'b0);
        busy_cyc = 0; lat = -1; start_len = 0; bits = '0;
        for (int c = 0; c < 400; c++) begin
            trace[c] = cur_tx(sel);
            if (cur_busy(sel) === 1'b1) busy_cyc++;
            else break;
            @(posedge clk); #1;
        end
        total++;
        if (cur_busy(sel) !== 1'b0) $display("FAIL frame_timeout sel=%0d busy=%b want=0", sel, cur_busy(sel));
        else passed++;
        for (int c = 0; c < 400; c++) if (trace[c] === 1'b0) begin lat = c; break; end
        if (lat >= 0) begin
            for (int c = lat; c < 640 && trace[c] === 1'b0; c++) start_len++;
            for (int i = 0; i < nb; i++) bits[i] = trace[lat + 5 + 10*i];
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (tx_a !== 1'b1) $display("FAIL reset_tx got=%b want=1", tx_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_a); else passed++;
        if (rdy_a !== 1'b1) $display("FAIL reset_ready got=%b want=1", rdy_a); else passed++;
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_tick_setup();
        @(negedge clk); #1;
        drive(0, 8'hA5, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'h00, 1'b0);
        repeat (54) begin @(posedge clk); #1; end
        total += 2;
        if (busy_a !== 1'b1) $display("FAIL midframe_busy got=%b want=1", busy_a); else passed++;
        if (tx_a !== 1'b0) $display("FAIL midframe_bit3 got=%b want=0", tx_a); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (tx_a !== 1'b1) $display("FAIL async_reset_tx got=%b want=1", tx_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL async_reset_busy got=%b want=0", busy_a); else passed++;
        if (rdy_a !== 1'b1) $display("FAIL async_reset_ready got=%b want=1", rdy_a); else passed++;
        @(negedge clk); #1;
        rst_n = 1'b1;
        begin
            int lat, bc, sl;
            logic [15:0] bits;
            run_frame(0, 8'h3C, 1'b0, NB_A, lat, bc, bits, sl);
            total++;
            if (bits !== E_3C) $display("FAIL post_reset_frame got=%h want=%h", bits, E_3C); else passed++;
        end
    endtask

    task automatic test_basic();
        int lat, bc, sl;
        logic [15:0] bits;
        run_frame(0, 8'hA5, 1'b0, NB_A, lat, bc, bits, sl);
        total += 5;
        if (bits !== E_A5) $display("FAIL a5_frame got=%h want=%h", bits, E_A5); else passed++;
        if (lat !== 9) $display("FAIL a5_latency got=%0d want=9", lat); else passed++;
        if (bc !== 9 + 10*NB_A) $display("FAIL a5_busy_len got=%0d want=%0d", bc, 9 + 10*NB_A); else passed++;
        if (rdy_a !== 1'b1) $display("FAIL a5_ready_after got=%b want=1", rdy_a); else passed++;
        if (tx_a !== 1'b1) $display("FAIL a5_idle_tx got=%b want=1", tx_a); else passed++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int lat, bc, sl;
        logic [15:0] bits;
        run_frame(0, 8'h01, 1'b0, NB_A, lat, bc, bits, sl);
        total += 2;
        if (bits !== 16'h0602) $display("FAIL even_parity_01 got=%h want=0602", bits); else passed++;
        if (bc !== 9 + 110) $display("FAIL parity_busy_len got=%0d want=119", bc); else passed++;
        run_frame(2, 8'hA5, 1'b0, NB_A, lat, bc, bits, sl);
        total += 1;
        if (bits !== 16'h074A) $display("FAIL odd_parity_a5 got=%h want=074A", bits); else passed++;
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int acc [3];
        int k, f, st;
        bit done, will;
        logic [15:0] got, want;
        words = '{8'h00, 8'hFF, 8'h55};
        acc = '{-1, -1, -1};
        for (int c = 0; c < 640; c++) begin trace[c] = 1'bx; btrace[c] = 1'bx; end
        k = 0; done = 1'b0;
        data_a = words[0]; valid_a = 1'b1;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk); #1;
            will = valid_a & rdy_a;
            @(posedge clk); #1;
            trace[c] = tx_a; btrace[c] = busy_a;
            if (will && k < 3) begin
                acc[k] = c; k++;
                if (k < 3) data_a = words[k]; else valid_a = 1'b0;
            end
            if (k == 3 && busy_a === 1'b0) done = 1'b1;
        end
        valid_a = 1'b0;
        total += 2;
        if (!done) $display("FAIL b2b_timeout got=%0d accepts want=3 done", k); else passed++;
        if (k !== 3) $display("FAIL b2b_accepts got=%0d want=3", k); else passed++;
        for (int j = 1; j < 3; j++) begin
            f = -1;
            for (int c = acc[j-1] + 1; c >= 1 && c < 640; c++) if (btrace[c] === 1'b0) begin f = c; break; end
            total++;
            if (acc[j] !== f + 1) $display("FAIL b2b_accept_gap%0d got=%0d want=%0d", j, acc[j], f + 1);
            else passed++;
        end
        for (int j = 0; j < 3; j++) begin
            st = -1; got = '0;
            for (int c = (acc[j] < 0 ? 0 : acc[j]); c < 640; c++) if (trace[c] === 1'b0) begin st = c; break; end
            if (st >= 0) for (int i = 0; i < NB_A; i++) got[i] = (st + 5 + 10*i < 640) ? trace[st + 5 + 10*i] : 1'bx;
            want = exp_frame(words[j], 8, 1);
            total++;
            if (got !== want) $display("FAIL b2b_frame%0d got=%h want=%h", j, got, want); else passed++;
        end
    endtask

    task automatic test_same_tick();
        int lat, bc, sl;
        logic [15:0] bits;
        run_frame(0, 8'hA5, 1'b1, NB_A, lat, bc, bits, sl);
        total += 4;
        if (lat !== 10) $display("FAIL same_tick_latency got=%0d want=10", lat); else passed++;
        if (sl !== 10) $display("FAIL same_tick_start_len got=%0d want=10", sl); else passed++;
        if (bits !== E_A5) $display("FAIL same_tick_frame got=%h want=%h", bits, E_A5); else passed++;
        if (bc !== 10 + 10*NB_A) $display("FAIL same_tick_busy got=%0d want=%0d", bc, 10 + 10*NB_A); else passed++;
    endtask

    task automatic test_stop2();
        int lat, bc, sl;
        bit hi;
        logic [15:0] bits;
        run_frame(1, 8'h7F, 1'b0, NB_B, lat, bc, bits, sl);
        hi = 1'b1;
        for (int c = lat + 10*(8 + P); c < bc && c >= 0; c++) if (trace[c] !== 1'b1) hi = 1'b0;
        total += 5;
        if (bits !== E_7F) $display("FAIL stop2_frame got=%h want=%h", bits, E_7F); else passed++;
        if (lat !== 9) $display("FAIL stop2_latency got=%0d want=9", lat); else passed++;
        if (bc !== 9 + 10*NB_B) $display("FAIL stop2_busy_len got=%0d want=%0d", bc, 9 + 10*NB_B); else passed++;
        if (!hi) $display("FAIL stop2_line_high got=0 want=1"); else passed++;
        if (rdy_b !== 1'b1) $display("FAIL stop2_ready_after got=%b want=1", rdy_b); else passed++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_same_tick();
        test_stop2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
